mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sequencing front-end sitting directly upstream of the data memory block. It sits between the pipeline MEM stage and the memory.
- Accepts one load/store request at a time over a valid/ready handshake and range-checks the address.
- Drives the memory's level-sensitive read/write/byte strobes for a fixed number of cycles, then returns extended load data or a fault over a second valid/ready handshake.

Parameters:
- MEM_BYTES, 128: size of the data memory in bytes; highest legal byte address is MEM_BYTES-1.
- MEM_LATENCY, 2: number of cycles strobes are held (1..15); read data is sampled on the last cycle.
- ADDR_W, 18: byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1=store, 0=load.
- req_byte  in  1  1=byte access, 0=word access.
- req_signed  in  1  byte loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; byte stores use [7:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result; 0 for stores and faults.
- rsp_fault  out  1  out-of-range access; no memory strobe was issued.
- mem_read  out  1  to memory memRead.
- mem_write  out  1  to memory memWrite.
- mem_byte  out  1  to memory byteOperations.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  32  to memory write_data.
- mem_rdata  in  32  from memory read_data.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- FSM states: IDLE, ACCESS, RESP.
- Reset values: state=IDLE, so req_ready=1. rsp_valid=0, rsp_fault=0, rsp_rdata=0. All mem_* outputs=0. Cycle counter=0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write/byte/signed/addr/wdata.
  - Range check uses a ADDR_W+1-bit sum so there is no wrap. Byte access is legal if addr<MEM_BYTES. Word access is legal if addr+3<MEM_BYTES.
  - Illegal: go to RESP with rsp_fault=1 and rsp_rdata=0.
  - Legal: go to ACCESS.
- ACCESS:
  - req_ready=0.
  - mem_addr, mem_byte and mem_wdata are held at the latched values for exactly MEM_LATENCY cycles. mem_read (load) or mem_write (store) is held high for the same period; never both.
  - On the last ACCESS cycle, register mem_rdata and go to RESP.
- Extension of the sampled mem_rdata:
  - Word load: returned unchanged.
  - Byte load: uses [7:0]; sign-extended if signed, else zero-extended.
  - Store: rdata=0.
- Outside ACCESS, all mem_* outputs are 0. This means no stray address/data change can retrigger the combinational memory write.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_fault are stable until the handshake.
  - On rsp_ready, go to IDLE and clear rsp_valid/rsp_fault/rsp_rdata.
  - req_ready stays 0 in RESP; a new request is accepted only in the following IDLE cycle.
- Latency, with the request accepted at edge T:
  - Legal access: strobes high for cycles T+1..T+MEM_LATENCY; rsp_valid=1 from T+MEM_LATENCY+1.
  - Fault: rsp_valid=1 from T+1; strobes are never raised.
- rsp_ready held low: state stays RESP indefinitely, outputs are frozen, and no memory activity occurs.
- Reset mid-ACCESS or mid-RESP: on that edge return to IDLE and drop all strobes/outputs. The in-flight request is discarded with no response. A store may be partially applied; this is accepted.
- Inputs req_* are ignored outside IDLE.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: a word access with addr[1:0]!=0 also faults. It takes the fault path: rsp_valid at T+1, rsp_fault=1, no strobes.
- Undefined: unaligned word accesses are legal subject only to the range check. Byte accesses are never affected.

Decomposition:
- Package mem_access_pkg holds:
  - the state enum (IDLE/ACCESS/RESP);
  - MEM_BYTES_DEFAULT=128 and MEM_LATENCY_DEFAULT=2;
  - the word width constant 32.
- One natural combinational sub-module, load_extend. Inputs: raw word, byte, signed, write. Output: 32-bit result.
- The FSM, counter and range check stay in the top module.

Test Plan:
- Memory bytes at 0..3 = 0x78,0x56,0x34,0x12. Word load at addr 0 -> mem_read high for exactly 2 cycles; rsp_rdata=0x12345678; rsp_fault=0; rsp_valid at accept+3.
- Byte at addr 4 = 0x80. Signed byte load -> 0xFFFFFF80. Unsigned byte load -> 0x00000080.
- Word store 0xDEADBEEF at addr 8, then word load at 8 -> 0xDEADBEEF. During the store, mem_write=1 and mem_read=0 for 2 cycles. Store response rdata=0.
- Range boundaries:
  - Word load at addr 125 -> fault at accept+1, with mem_read/mem_write never asserted.
  - Word load at addr 124 -> legal.
  - Byte load at addr 127 -> legal.
  - Byte load at addr 128 -> fault.
- Response backpressure and reset:
  - Hold rsp_ready=0 for 10 cycles -> rsp_valid and rdata stable, req_ready=0. Release -> IDLE next cycle.
  - Assert rst during ACCESS -> next cycle all outputs at reset values, req_ready=1, no response ever emitted.
- Alignment macro: word load at addr 2 -> with MEM_ACCESS_ALIGN_CHECK_EN, fault and no strobes; without it, returns bytes 2..5 assembled.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants and state encoding for the memory access unit.
// Contents: word width, default memory size/latency, FSM state constants.
package mem_access_pkg;

    localparam int WORD_W              = 32;
    localparam int MEM_BYTES_DEFAULT   = 128;
    localparam int MEM_LATENCY_DEFAULT = 2;

    // Sequencer states (IDLE / ACCESS / RESP)
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;

endpackage

// File: rtl/load_extend.sv
// Shapes the raw memory word into the value returned to the pipeline.
// Ports:
//   raw_word  in  32  word sampled from memory
//   byte_op   in  1   byte access: only [7:0] is meaningful
//   signed_op in  1   byte loads: sign-extend instead of zero-extend
//   write_op  in  1   store: result is forced to zero
//   result    out 32  extended load data
module load_extend
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] raw_word,
    input  logic              byte_op,
    input  logic              signed_op,
    input  logic              write_op,
    output logic [WORD_W-1:0] result
);

    always_comb begin
        result = '0;
        if (write_op) begin
            result = '0;
        end else if (byte_op) begin
            if (signed_op) begin
                result = {{(WORD_W - 8){raw_word[7]}}, raw_word[7:0]};
            end else begin
                result = {{(WORD_W - 8){1'b0}}, raw_word[7:0]};
            end
        end else begin
            result = raw_word;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sequencing front-end between the MEM stage and the data memory. Accepts one
// load/store at a time, range-checks it, holds the memory strobes for
// MEM_LATENCY cycles, then returns extended load data or a fault.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN: word accesses with addr[1:0]!=0
// take the fault path.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_write/byte/signed/addr/wdata  request fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_fault            response payload
//   mem_read/write/byte/addr/wdata  level-sensitive memory strobes
//   mem_rdata                       memory read data
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES   = MEM_BYTES_DEFAULT,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    // One extra bit so addr+3 never wraps past the top of the address space.
    localparam int                SUM_W    = ADDR_W + 1;
    localparam logic [SUM_W-1:0]  LIMIT    = SUM_W'(MEM_BYTES);
    localparam logic [3:0]        LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                write_q;
    logic                byte_q;
    logic                signed_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   rdata_q;
    logic                fault_q;

    logic [SUM_W-1:0]    last_byte;
    logic                in_range;
    logic                misaligned;
    logic                accept;
    logic [WORD_W-1:0]   ext_rdata;

    assign last_byte = {1'b0, req_addr} + (req_byte ? SUM_W'(0) : SUM_W'(3));
    assign in_range  = last_byte < LIMIT;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misaligned = !req_byte && (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

    load_extend u_load_extend (
        .raw_word  (mem_rdata),
        .byte_op   (byte_q),
        .signed_op (signed_q),
        .write_op  (write_q),
        .result    (ext_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q  <= req_write;
                        byte_q   <= req_byte;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        cnt_q    <= '0;
                        if (!in_range || misaligned) begin
                            fault_q <= 1'b1;
                            rdata_q <= '0;
                            state_q <= RESP;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == LAST_CNT) begin
                        rdata_q <= ext_rdata;
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        fault_q <= 1'b0;
                        rdata_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes and address/data only leave zero while ACCESS, so the
    // combinational memory never sees stray write activity.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_byte  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ACCESS) begin
            mem_read  = !write_q;
            mem_write = write_q;
            mem_byte  = byte_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int ADDR_W = 18;
    localparam int NBYTES = 128;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic              req_byte = 1'b0;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic              mem_read;
    logic              mem_write;
    logic              mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    mem_access_unit #(
        .MEM_BYTES   (NBYTES),
        .MEM_LATENCY (LAT),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_byte   (mem_byte),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Memory device seen by the DUT
    logic [7:0] img [0:NBYTES-1];
    logic [7:0] dmem [0:NBYTES-1];
    logic       load_img = 1'b1;

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < NBYTES; i++) dmem[i] <= img[i];
        end else if (mem_write) begin
            for (int k = 0; k < 4; k++) begin
                if ((k == 0 || !mem_byte) && (int'(mem_addr) + k < NBYTES))
                    dmem[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
            end
        end
    end

    function automatic logic [7:0] rd_byte(input int a);
        return (a < NBYTES) ? dmem[a] : 8'h00;
    endfunction

    always_comb begin
        mem_rdata = {rd_byte(int'(mem_addr) + 3), rd_byte(int'(mem_addr) + 2),
                     rd_byte(int'(mem_addr) + 1), rd_byte(int'(mem_addr))};
    end

    // Reference model
    typedef struct {
        logic [31:0]       rdata;
        logic              fault;
        int                acc;
        int                lat;
        int                rd;
        int                wr;
        logic [ADDR_W-1:0] addr;
        logic              bop;
        logic [31:0]       wdata;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] model_mem [0:NBYTES-1];

    function automatic exp_t model(input logic w, input logic b, input logic s,
                                   input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_t e;
        int   base = int'(a);
        int   nb   = b ? 1 : 4;
        bit   bad  = (base + nb - 1) >= NBYTES;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if (!b && (base % 4) != 0) bad = 1;
`endif
        e.addr = a; e.bop = b; e.wdata = d; e.acc = 0;
        e.rdata = 32'h0; e.fault = bad;
        e.lat = bad ? 1 : LAT + 1;
        e.rd  = (bad || w) ? 0 : LAT;
        e.wr  = (bad || !w) ? 0 : LAT;
        if (!bad && w) begin
            for (int k = 0; k < nb; k++) model_mem[base + k] = d[8*k +: 8];
        end else if (!bad) begin
            int v = 0;
            for (int k = nb - 1; k >= 0; k--) v = v * 256 + int'(model_mem[base + k]);
            if (b && s && v >= 128) v = v - 256;
            e.rdata = 32'(v);
        end
        return e;
    endfunction

    // Response backpressure: 0 random, 1 held low, 2 held high
    int bp_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       rsp_ready = ($urandom_range(0, 3) != 0);
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    bit          stray = 0;
    bit          in_resp = 0;
    bit          chk_idle = 0;
    exp_t        cur;
    logic [31:0] hold_rdata;
    logic        hold_fault;

    always @(negedge clk) begin
        if (rst) begin
            rd_cnt = 0; wr_cnt = 0; stray = 0; in_resp = 0; chk_idle = 0;
        end else begin
            if (chk_idle) begin
                chk(req_ready && !rsp_valid && !rsp_fault && rsp_rdata == 0, "idle_after_rsp",
                    {28'h0, req_ready, rsp_valid, rsp_fault, |rsp_rdata}, 32'h8);
                chk_idle = 0;
            end
            if (mem_read || mem_write) begin
                if (mem_read) rd_cnt++;
                if (mem_write) wr_cnt++;
                if (mem_read && mem_write) stray = 1;
                if (exp_q.size() == 0) stray = 1;
                else if (mem_addr != exp_q[0].addr || mem_byte != exp_q[0].bop ||
                         mem_wdata != exp_q[0].wdata) stray = 1;
            end else if (mem_byte || mem_addr != '0 || mem_wdata != '0) begin
                stray = 1;
            end
            if (rsp_valid) begin
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0 == rsp_valid, "unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk(rsp_rdata == cur.rdata, "rsp_rdata", rsp_rdata, cur.rdata);
                        chk(rsp_fault == cur.fault, "rsp_fault", {31'h0, rsp_fault},
                            {31'h0, cur.fault});
                        chk(cyc - cur.acc == cur.lat, "rsp_latency", 32'(cyc - cur.acc),
                            32'(cur.lat));
                        chk(rd_cnt == cur.rd && wr_cnt == cur.wr && !stray, "strobes",
                            32'(rd_cnt * 256 + wr_cnt * 16 + int'(stray)),
                            32'(cur.rd * 256 + cur.wr * 16));
                    end
                    hold_rdata = rsp_rdata;
                    hold_fault = rsp_fault;
                    in_resp = 1;
                end else begin
                    chk(rsp_rdata == hold_rdata && rsp_fault == hold_fault && !req_ready,
                        "rsp_hold", rsp_rdata, hold_rdata);
                end
                if (rsp_ready) begin
                    in_resp = 0; rd_cnt = 0; wr_cnt = 0; stray = 0; chk_idle = 1;
                end
            end
        end
    end

    // Driver
    task automatic do_req(input logic w, input logic b, input logic s,
                          input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_t e;
        int   waited = 0;
        bit   done = 0;
        req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
        req_addr = a; req_wdata = d;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                e = model(w, b, s, a, d);
                e.acc = cyc;
                exp_q.push_back(e);
                done = 1;
            end else if (++waited > 300) begin
                chk(req_ready, "req_ready_timeout", {31'h0, req_ready}, 32'h1);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        // Scramble request fields while not valid; the DUT must ignore them.
        req_valid = 1'b0;
        req_write = 1'($urandom); req_byte = 1'($urandom); req_signed = 1'($urandom);
        req_addr = ADDR_W'($urandom); req_wdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(exp_q.size() == 0 && req_ready, "drain", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NBYTES; i++) begin
            img[i] = 8'($urandom);
        end
        img[0] = 8'h78; img[1] = 8'h56; img[2] = 8'h34; img[3] = 8'h12; img[4] = 8'h80;
        img[5] = 8'h9A;
        for (int i = 0; i < NBYTES; i++) model_mem[i] = img[i];

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        load_img = 1'b0;
        @(negedge clk);
        chk(req_ready && !rsp_valid && !rsp_fault && rsp_rdata == 0, "reset_rsp",
            {28'h0, req_ready, rsp_valid, rsp_fault, |rsp_rdata}, 32'h8);
        chk(!mem_read && !mem_write && !mem_byte && mem_addr == 0 && mem_wdata == 0,
            "reset_mem", {29'h0, mem_read, mem_write, mem_byte}, 32'h0);
        @(posedge clk);
        #1;

        // Directed: loads, extension, store/reload, range boundaries, alignment
        do_req(1'b0, 1'b0, 1'b0, 18'd0, 32'h0);
        do_req(1'b0, 1'b1, 1'b1, 18'd4, 32'h0);
        do_req(1'b0, 1'b1, 1'b0, 18'd4, 32'h0);
        do_req(1'b1, 1'b0, 1'b0, 18'd8, 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 1'b0, 18'd8, 32'h0);
        do_req(1'b0, 1'b0, 1'b0, 18'd125, 32'h0);
        do_req(1'b0, 1'b0, 1'b0, 18'd124, 32'h0);
        do_req(1'b0, 1'b1, 1'b0, 18'd127, 32'h0);
        do_req(1'b0, 1'b1, 1'b0, 18'd128, 32'h0);
        do_req(1'b1, 1'b0, 1'b0, 18'h3FFFF, 32'h11223344);
        do_req(1'b0, 1'b1, 1'b1, 18'h3FFFF, 32'h0);
        do_req(1'b0, 1'b0, 1'b0, 18'd2, 32'h0);
        drain();

        // Backpressure: response must freeze while rsp_ready is low
        bp_mode = 1;
        do_req(1'b0, 1'b0, 1'b0, 18'd0, 32'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk(rsp_valid && !req_ready && rsp_rdata == 32'h12345678, "bp_hold", rsp_rdata,
            32'h12345678);
        @(posedge clk);
        #1;
        bp_mode = 2;
        drain();

        // Reset during ACCESS: request discarded, no response
        do_req(1'b0, 1'b0, 1'b0, 18'd0, 32'h0);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(req_ready && !rsp_valid && !rsp_fault && rsp_rdata == 0, "abort_rsp",
            {28'h0, req_ready, rsp_valid, rsp_fault, |rsp_rdata}, 32'h8);
        chk(!mem_read && !mem_write && !mem_byte && mem_addr == 0 && mem_wdata == 0,
            "abort_mem", {29'h0, mem_read, mem_write, mem_byte}, 32'h0);
        repeat (6) @(negedge clk);
        chk(!rsp_valid && req_ready, "abort_quiet", {30'h0, rsp_valid, req_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        bp_mode = 0;
        for (int i = 0; i < 150; i++) begin
            logic [ADDR_W-1:0] a;
            int sel = $urandom_range(0, 9);
            if (sel < 8) a = ADDR_W'($urandom_range(0, 131));
            else if (sel == 8) a = ADDR_W'($urandom_range(120, 135));
            else a = ADDR_W'($urandom);
            do_req(1'($urandom), 1'($urandom), 1'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        bp_mode = 2;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
